fifo_stream_reader: RTL

- Consumer-side engine for the byte FIFO top: the read-side partner of the write port.
- Pops bytes by driving the FIFO's `rd_sig` and absorbs the FIFO's 1-cycle registered read latency.
- Re-presents the data on a valid/ready stream port through a 2-entry skid buffer.
- Provides start/stop control, a popped-byte counter and a sticky error flag for FIFO `under_flow`.

---
 rtl/fifo_stream_reader.sv | 91 +++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side engine for the byte FIFO: issues credit-limited pops, absorbs the
// FIFO's one-cycle read latency and re-presents bytes on a valid/ready stream.
module fifo_stream_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              empty_sig,
  input  logic              under_flow,
  input  logic [DATA_W-1:0] dout,
  output logic              rd_sig,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  pop_cnt,
  output logic              err
);

  typedef enum logic [1:0] {STOP, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic              inflight_q;
  logic [1:0]        occ_q, occ_d;
  logic              head_q, head_d;
  logic [DATA_W-1:0] mem_q [2];
  logic [CNT_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic              err_q, err_d;

  logic              pop;
  logic              push;
  logic              drop;
  logic              credit_ok;
  logic              wr_idx;

  always_comb begin
    m_valid   = (occ_q != 2'd0);
    m_data    = mem_q[head_q];
    pop       = m_valid & m_ready;
    // occ + inflight - pop < 2, rearranged to stay non-negative
    credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    rd_sig    = (state_q == RUN) & ~empty_sig & credit_ok;
    push      = inflight_q & (occ_q != 2'd2);
    drop      = inflight_q & (occ_q == 2'd2);
    wr_idx    = head_q ^ occ_q[0];
    occ_d     = occ_q + {1'b0, push} - {1'b0, pop};
    head_d    = head_q ^ pop;
    pop_cnt_d = pop_cnt_q + {{(CNT_W-1){1'b0}}, inflight_q};
    err_d     = err_q | under_flow | (rd_sig & empty_sig) | drop;
    busy      = (state_q != STOP) | inflight_q | (occ_q != 2'd0);
    pop_cnt   = pop_cnt_q;
    err       = err_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STOP:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en)                                   state_d = RUN;
        else if (!inflight_q && occ_q == 2'd0)    state_d = STOP;
      end
      default: state_d = STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= STOP;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      pop_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_sig;
      occ_q      <= occ_d;
      head_q     <= head_d;
      pop_cnt_q  <= pop_cnt_d;
      err_q      <= err_d;
      if (push) mem_q[wr_idx] <= dout;
    end
  end

endmodule
